// File: rtl/rv_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rv_fetch_pkg                                                      |
// | Brief  : Shared widths, reset constants and buffer entry type for fetch.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package rv_fetch_pkg;

  localparam int               XLEN      = 32;
  localparam logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fetch_buffer                                                      |
// | Brief  : Two-entry in-order {pc, instr} FIFO with flush; head is entry0.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module fetch_buffer
  import rv_fetch_pkg::*;
#(
  parameter fetch_entry_t RESET_ENTRY = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t entry0;
  fetch_entry_t entry1;
  logic [1:0]   cnt;
  logic         do_pop;

  assign do_pop = pop & (cnt != 2'd0);
  assign count  = cnt;
  assign head   = entry0;

  // Flush wins over a same-cycle push so a redirect never leaks a stale word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0 <= RESET_ENTRY;
      entry1 <= RESET_ENTRY;
      cnt    <= 2'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) entry0 <= push_data;
          else             entry1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          cnt    <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            entry0 <= push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fetch_unit                                                        |
// | Brief  : PC owner and imem requester; feeds decode from a 2-entry buffer.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module fetch_unit #(
  parameter int               XLEN      = rv_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC  = rv_fetch_pkg::RESET_PC,
  parameter logic [XLEN-1:0]  NOP_INSTR = rv_fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall_i,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] imm_ext_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o
);

  import rv_fetch_pkg::*;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] tag_pc;
  logic [XLEN-1:0] target_pc;
  logic            outstanding;
  logic            drop;
  logic            fire;
  logic            redirect;
  logic            grant;
  logic            resp;
  logic            push;
  logic [1:0]      count;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  assign instr_valid_o = (count != 2'd0);
  assign fire          = instr_valid_o & ~stall_i;
  assign redirect      = fire & PCSrc;

  // Gating with rst_n keeps the request low while reset is held.
  assign imem_req  = rst_n & ~outstanding & ~count[1] & ~redirect;
  assign imem_addr = fetch_pc;
  assign grant     = imem_req & imem_gnt;
  assign resp      = imem_rvalid & outstanding;
  assign push      = resp & ~drop;

  assign target_pc  = (pc_o + imm_ext_i) & ~XLEN'(3);
  assign push_entry = '{pc: tag_pc, instr: imem_rdata};

  assign pc_o       = head.pc;
  assign instr_o    = instr_valid_o ? head.instr : NOP_INSTR;
  assign pc_plus4_o = pc_o + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      tag_pc      <= RESET_PC;
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else begin
      if (grant) begin
        outstanding <= 1'b1;
        tag_pc      <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end
      if (resp) begin
        outstanding <= 1'b0;
        if (drop) drop <= 1'b0;
      end
      // A redirect never coincides with a grant because it masks imem_req.
      if (redirect) begin
        fetch_pc <= target_pc;
        drop     <= outstanding & ~imem_rvalid;
      end
    end
  end

  fetch_buffer #(
    .RESET_ENTRY ({RESET_PC, NOP_INSTR})
  ) u_fetch_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (fire),
    .flush     (redirect),
    .count     (count),
    .head      (head)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_fetch_unit                                                     |
// | Brief  : Directed scoreboard bench for fetch_unit with a simple imem.      |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        pcsrc;
  logic [31:0] imm;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;

  int          checks   = 0;
  int          failures = 0;
  int          lat      = 1;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr[$];
  logic [31:0] sb_e;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .stall_i       (stall),
    .PCSrc         (pcsrc),
    .imm_ext_i     (imm),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [31:0] p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(instr_valid_o && pc_o == p) && n < 60);
    checks++;
    if (!(instr_valid_o && pc_o == p)) begin
      failures++;
      $display("FAIL wait_pc: actual pc_o=%h valid=%b, required valid pc %h", pc_o, instr_valid_o, p);
    end
  endtask

  // Instruction memory: one request in flight, response lat cycles after grant.
  initial begin
    logic [31:0] ga;
    int          gl;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req && imem_gnt) begin
        ga = imem_addr;
        gl = lat;
        if (exp_addr.size() != 0) chk("grant_addr", ga, exp_addr.pop_front());
        @(posedge clk);
        repeat (gl - 1) @(posedge clk);
        #1;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(ga);
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every consumed instruction must match the next expectation.
  always @(negedge clk) begin
    if (rst_n && instr_valid_o && !stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: actual pc_o=%h, required no instruction", pc_o);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_pc", pc_o, sb_e);
        chk("sb_instr", instr_o, mem_word(sb_e));
        chk("sb_pc4", pc_plus4_o, sb_e + 32'd4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b1; stall = 1'b0; pcsrc = 1'b0; imm = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, NOP);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_pc4", pc_plus4_o, 32'h4);

    // Streaming, stall fill, grant backpressure
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h8);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("t1_req_first", {31'b0, imem_req}, 32'd1);
    chk("t1_addr_first", imem_addr, 32'h0);
    @(negedge clk);
    chk("t1_valid_early", {31'b0, instr_valid_o}, 32'd0);
    @(negedge clk);
    chk("t1_valid_first", {31'b0, instr_valid_o}, 32'd1);
    wait_pc(32'h8);

    tick(); stall = 1'b1;
    repeat (5) @(negedge clk);
    chk("t2_req_full", {31'b0, imem_req}, 32'd0);
    chk("t2_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("t2_pc_hold", pc_o, 32'hC);
    chk("t2_instr_hold", instr_o, mem_word(32'hC));

    tick(); stall = 1'b0; imem_gnt = 1'b0;
    @(negedge clk);
    chk("t3_req_full", {31'b0, imem_req}, 32'd0);
    exp_addr.push_back(32'h14);
    repeat (3) begin
      @(negedge clk);
      chk("t3_req_held", {31'b0, imem_req}, 32'd1);
      chk("t3_addr_stable", imem_addr, 32'h14);
    end
    tick(); imem_gnt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_addr_adv", imem_addr, 32'h18);
    wait_pc(32'h18);

    // Branch back to 0 with a response in flight; then stalled redirect
    tick(); rst_n = 1'b0;
    exp_q.delete(); exp_addr.delete();
    foreach (exp_q[i]) exp_q[i] = 32'h0;
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h48 + 32'(i * 4));
    tick(); tick(); rst_n = 1'b1;
    wait_pc(32'hC);
    tick(); stall = 1'b1; lat = 3;
    @(negedge clk);
    @(negedge clk);
    chk("t4_pc_head", pc_o, 32'h10);
    chk("t4_req_next", {31'b0, imem_req}, 32'd1);
    tick(); stall = 1'b0; pcsrc = 1'b1; imm = 32'hFFFF_FFF0;
    @(negedge clk);
    chk("t4_req_suppr", {31'b0, imem_req}, 32'd0);
    tick(); pcsrc = 1'b0; imm = 32'h0; lat = 1; exp_addr.push_back(32'h0);
    @(negedge clk);
    chk("t4_flushed", {31'b0, instr_valid_o}, 32'd0);
    @(negedge clk);
    chk("t4_req_wait", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    chk("t4_req_target", {31'b0, imem_req}, 32'd1);
    chk("t4_addr_target", imem_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("t4_valid_target", {31'b0, instr_valid_o}, 32'd1);
    chk("t4_pc_target", pc_o, 32'h0);

    wait_pc(32'h4);
    tick(); stall = 1'b1; pcsrc = 1'b1; imm = 32'h42;
    repeat (5) @(negedge clk);
    chk("t5_valid_stalled", {31'b0, instr_valid_o}, 32'd1);
    chk("t5_pc_stalled", pc_o, 32'h8);
    chk("t5_req_stalled", {31'b0, imem_req}, 32'd0);
    tick(); stall = 1'b0; exp_addr.push_back(32'h48);
    @(negedge clk);
    chk("t5_req_suppr", {31'b0, imem_req}, 32'd0);
    tick(); pcsrc = 1'b0; imm = 32'h0;
    @(negedge clk);
    chk("t5_addr_target", imem_addr, 32'h48);
    @(negedge clk);
    chk("t5_flushed", {31'b0, instr_valid_o}, 32'd0);
    @(negedge clk);
    chk("t5_valid_3cyc", {31'b0, instr_valid_o}, 32'd1);
    chk("t5_pc_3cyc", pc_o, 32'h48);
    wait_pc(32'h50);

    // Reset with a request in flight; the late response must be ignored
    tick(); rst_n = 1'b0;
    exp_q.delete(); exp_addr.delete();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    tick(); tick(); lat = 4; rst_n = 1'b1;
    @(negedge clk);
    tick(); rst_n = 1'b0; imem_gnt = 1'b0;
    @(negedge clk);
    chk("t6_req_in_rst", {31'b0, imem_req}, 32'd0);
    chk("t6_valid_in_rst", {31'b0, instr_valid_o}, 32'd0);
    tick(); rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_valid_late", {31'b0, instr_valid_o}, 32'd0);
      chk("t6_req_late", {31'b0, imem_req}, 32'd1);
      chk("t6_addr_late", imem_addr, 32'h0);
    end
    tick(); imem_gnt = 1'b1; lat = 1; exp_addr.push_back(32'h0);
    @(negedge clk);
    chk("t6_valid_after", {31'b0, instr_valid_o}, 32'd0);
    @(negedge clk);
    chk("t6_valid_resp", {31'b0, instr_valid_o}, 32'd0);
    @(negedge clk);
    chk("t6_valid_fresh", {31'b0, instr_valid_o}, 32'd1);
    chk("t6_pc_fresh", pc_o, 32'h0);
    wait_pc(32'h8);
    tick(); stall = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
